// File: rtl/raisin64_sched_pkg.sv
// Shared definitions for the issue scheduler: unit encoding, register-file geometry
// and the pending-table vector type.
package raisin64_sched_pkg;

    localparam int unsigned NUM_UNITS = 8;
    localparam int unsigned UNIT_W    = 3;
    localparam int unsigned NREGS     = 64;
    localparam int unsigned RN_W      = 6;

    // Execution-unit indices as carried in the decode unit field
    localparam logic [UNIT_W-1:0] UNIT_ALU0 = 3'd0;
    localparam logic [UNIT_W-1:0] UNIT_ALU1 = 3'd1;
    localparam logic [UNIT_W-1:0] UNIT_LSU  = 3'd2;
    localparam logic [UNIT_W-1:0] UNIT_BRU  = 3'd3;
    localparam logic [UNIT_W-1:0] UNIT_MUL  = 3'd4;
    localparam logic [UNIT_W-1:0] UNIT_DIV  = 3'd5;
    localparam logic [UNIT_W-1:0] UNIT_FPU  = 3'd6;
    localparam logic [UNIT_W-1:0] UNIT_SYS  = 3'd7;

    localparam logic [RN_W-1:0] REG_ZERO = '0;

    typedef logic [NREGS-1:0] pend_vec_t;

    // One-hot register mask; r0 never produces a bit since it is constant zero
    function automatic pend_vec_t rn_onehot(input logic [RN_W-1:0] rn);
        pend_vec_t v;
        v = '0;
        if (rn != REG_ZERO) begin
            v[rn] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sched_pending_table.sv
// Pending-write table: one bit per architectural register, set when an instruction
// that writes it issues and cleared by writeback. Four combinational lookup ports.
// Optional build macro SCHED_WB_BYPASS_EN: lookups see a register being cleared by
// a writeback this cycle as already not pending.
module sched_pending_table
    import raisin64_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        clr_en,
    input  logic [2*RN_W-1:0] clr_rn,
    input  logic [1:0]        set_en,
    input  logic [2*RN_W-1:0] set_rn,
    input  logic [4*RN_W-1:0] lkp_rn,
    output logic [3:0]        lkp_pend
);

    pend_vec_t pend_q;
    pend_vec_t pend_d;
    pend_vec_t clr_mask;
    pend_vec_t set_mask;
    pend_vec_t pend_eff;

    // Build clear/set masks and next table; sets are applied after clears so set wins
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int k = 0; k < 2; k++) begin
            if (clr_en[k]) begin
                clr_mask = clr_mask | rn_onehot(clr_rn[k*RN_W +: RN_W]);
            end
            if (set_en[k]) begin
                set_mask = set_mask | rn_onehot(set_rn[k*RN_W +: RN_W]);
            end
        end
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        pend_d[0] = 1'b0;
    end

    // View of the table used by the hazard lookups
    always_comb begin
`ifdef SCHED_WB_BYPASS_EN
        pend_eff = pend_q & ~clr_mask;
`else
        pend_eff = pend_q;
`endif
        for (int i = 0; i < 4; i++) begin
            lkp_pend[i] = pend_eff[lkp_rn[i*RN_W +: RN_W]];
        end
    end

    // Table state; reset drops every outstanding write, so late writebacks find nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard between decode and the execution units. Detects RAW/WAW hazards
// against the pending table and busy target units, stalls decode, and issues a
// one-hot strobe when the instruction is safe. Counts stalled cycles (saturating).
// Optional build macro SCHED_WB_BYPASS_EN (see sched_pending_table).
module issue_scoreboard
    import raisin64_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    input  logic [UNIT_W-1:0]    dec_unit,
    input  logic [RN_W-1:0]      dec_r1_rn,
    input  logic [RN_W-1:0]      dec_r2_rn,
    input  logic [RN_W-1:0]      dec_rd_rn,
    input  logic [RN_W-1:0]      dec_rd2_rn,
    input  logic                 dec_wr_rd,
    input  logic                 dec_wr_rd2,
    input  logic [NUM_UNITS-1:0] unit_busy,
    input  logic [1:0]           wb_valid,
    input  logic [2*RN_W-1:0]    wb_rn,
    output logic                 stall,
    output logic [NUM_UNITS-1:0] issue,
    output logic [CNT_W-1:0]     stall_cycles
);

    logic [3:0]       lkp_pend;
    logic             raw;
    logic             waw;
    logic             busy;
    logic             issue_any;
    logic [1:0]       set_en;
    logic [CNT_W-1:0] stall_cnt_q;

    sched_pending_table u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (wb_valid),
        .clr_rn   (wb_rn),
        .set_en   (set_en),
        .set_rn   ({dec_rd2_rn, dec_rd_rn}),
        .lkp_rn   ({dec_rd2_rn, dec_rd_rn, dec_r2_rn, dec_r1_rn}),
        .lkp_pend (lkp_pend)
    );

    // Same-cycle hazard decision and issue decode
    always_comb begin
        raw = ((dec_r1_rn != REG_ZERO) && lkp_pend[0]) ||
              ((dec_r2_rn != REG_ZERO) && lkp_pend[1]);
        waw = (dec_wr_rd  && (dec_rd_rn  != REG_ZERO) && lkp_pend[2]) ||
              (dec_wr_rd2 && (dec_rd2_rn != REG_ZERO) && lkp_pend[3]);
        busy      = unit_busy[dec_unit];
        stall     = dec_valid && (raw || waw || busy);
        issue_any = dec_valid && !stall;
        issue     = issue_any ? (NUM_UNITS'(1) << dec_unit) : '0;
        set_en    = {issue_any && dec_wr_rd2, issue_any && dec_wr_rd};
    end

    // Saturating count of cycles in which decode is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic, compared every cycle against a register-set reference model.
module tb_issue_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [2:0]  dec_unit;
    logic [5:0]  dec_r1_rn;
    logic [5:0]  dec_r2_rn;
    logic [5:0]  dec_rd_rn;
    logic [5:0]  dec_rd2_rn;
    logic        dec_wr_rd;
    logic        dec_wr_rd2;
    logic [7:0]  unit_busy;
    logic [1:0]  wb_valid;
    logic [11:0] wb_rn;
    logic        stall;
    logic [7:0]  issue;
    logic [31:0] stall_cycles;
    logic        stall_s;
    logic [7:0]  issue_s;
    logic [3:0]  stall_cycles_s;

    issue_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_unit     (dec_unit),
        .dec_r1_rn    (dec_r1_rn),
        .dec_r2_rn    (dec_r2_rn),
        .dec_rd_rn    (dec_rd_rn),
        .dec_rd2_rn   (dec_rd2_rn),
        .dec_wr_rd    (dec_wr_rd),
        .dec_wr_rd2   (dec_wr_rd2),
        .unit_busy    (unit_busy),
        .wb_valid     (wb_valid),
        .wb_rn        (wb_rn),
        .stall        (stall),
        .issue        (issue),
        .stall_cycles (stall_cycles)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    issue_scoreboard #(.CNT_W(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_unit     (dec_unit),
        .dec_r1_rn    (dec_r1_rn),
        .dec_r2_rn    (dec_r2_rn),
        .dec_rd_rn    (dec_rd_rn),
        .dec_rd2_rn   (dec_rd2_rn),
        .dec_wr_rd    (dec_wr_rd),
        .dec_wr_rd2   (dec_wr_rd2),
        .unit_busy    (unit_busy),
        .wb_valid     (wb_valid),
        .wb_rn        (wb_rn),
        .stall        (stall_s),
        .issue        (issue_s),
        .stall_cycles (stall_cycles_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit [63:0]   pend_m;
    logic [31:0] cnt_m;
    logic [3:0]  cnt_s_m;
    bit          exp_stall_v;
    logic [7:0]  exp_issue_v;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A register counts as outstanding for hazard purposes
    function automatic bit is_pend(input logic [5:0] rn);
        bit p;
        p = pend_m[rn];
`ifdef SCHED_WB_BYPASS_EN
        if (wb_valid[0] && wb_rn[5:0] == rn) p = 1'b0;
        if (wb_valid[1] && wb_rn[11:6] == rn) p = 1'b0;
`endif
        return (rn != 6'd0) && p;
    endfunction

    task automatic check_now(input string tag);
        exp_stall_v = dec_valid && (is_pend(dec_r1_rn) || is_pend(dec_r2_rn) ||
                      (dec_wr_rd && is_pend(dec_rd_rn)) || (dec_wr_rd2 && is_pend(dec_rd2_rn)) ||
                      unit_busy[dec_unit]);
        exp_issue_v = (dec_valid && !exp_stall_v) ? (8'h01 << dec_unit) : 8'h00;
        check_val({tag, ".stall"}, 64'(stall), 64'(exp_stall_v));
        check_val({tag, ".issue"}, 64'(issue), 64'(exp_issue_v));
        check_val({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(cnt_m));
        check_val({tag, ".sat_stall"}, 64'(stall_s), 64'(exp_stall_v));
        check_val({tag, ".sat_issue"}, 64'(issue_s), 64'(exp_issue_v));
        check_val({tag, ".sat_cycles"}, 64'(stall_cycles_s), 64'(cnt_s_m));
    endtask

    // Clock edge: apply writebacks, then issue-time sets (set wins), then counters
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (wb_valid[0]) pend_m[wb_rn[5:0]] = 1'b0;
            if (wb_valid[1]) pend_m[wb_rn[11:6]] = 1'b0;
            if (exp_issue_v != 8'h00) begin
                if (dec_wr_rd && dec_rd_rn != 6'd0) pend_m[dec_rd_rn] = 1'b1;
                if (dec_wr_rd2 && dec_rd2_rn != 6'd0) pend_m[dec_rd2_rn] = 1'b1;
            end
            if (exp_stall_v) begin
                if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
                if (cnt_s_m != 4'hF) cnt_s_m = cnt_s_m + 4'd1;
            end
        end
        #1;
    endtask

    task automatic run_cycle(input string tag);
        #3;
        check_now(tag);
        advance();
    endtask

    task automatic dec(input bit v, input int unit, input int r1, input int r2,
                       input int rd, input int rd2, input bit w1, input bit w2);
        dec_valid  = v;
        dec_unit   = 3'(unit);
        dec_r1_rn  = 6'(r1);
        dec_r2_rn  = 6'(r2);
        dec_rd_rn  = 6'(rd);
        dec_rd2_rn = 6'(rd2);
        dec_wr_rd  = w1;
        dec_wr_rd2 = w2;
    endtask

    task automatic wb(input bit v0, input int rn0, input bit v1, input int rn1);
        wb_valid = {v1, v0};
        wb_rn    = {6'(rn1), 6'(rn0)};
    endtask

    initial begin
        pend_m  = '0;
        cnt_m   = '0;
        cnt_s_m = '0;
        rst_n   = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0, 0);
        unit_busy = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state against fixed values
        #1;
        check_val("reset.stall", 64'(stall), 64'd0);
        check_val("reset.issue", 64'(issue), 64'd0);
        check_val("reset.stall_cycles", 64'(stall_cycles), 64'd0);
        check_val("reset.sat_cycles", 64'(stall_cycles_s), 64'd0);
        #2;
        check_now("reset");
        advance();

        // Basic issue marks rd pending
        dec(1, 2, 5, 0, 7, 0, 1, 0);
        #1;
        check_val("t1.issue_const", 64'(issue), 64'h04);
        #2;
        check_now("t1");
        advance();

        // RAW on r7 until writeback
        dec(1, 0, 7, 0, 0, 0, 0, 0);
        run_cycle("t2.wait0");
        run_cycle("t2.wait1");
        #1;
        check_val("t2.stall_const", 64'(stall), 64'd1);
        #2;
        check_now("t2.wait2");
        advance();
        wb(1, 7, 0, 0);
        run_cycle("t2.wb");
        wb(0, 0, 0, 0);
        run_cycle("t2.after");
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("t2.idle");

        // Writes to r0 never become pending
        dec(1, 1, 0, 0, 0, 0, 1, 1);
        run_cycle("t3.wr0");
        dec(1, 1, 0, 0, 0, 0, 0, 0);
        run_cycle("t3.rd0");

        // Busy unit holds decode
        unit_busy = 8'h10;
        dec(1, 4, 0, 0, 0, 0, 0, 0);
        run_cycle("t4.busy0");
        run_cycle("t4.busy1");
        run_cycle("t4.busy2");
        unit_busy = 8'h00;
        #1;
        check_val("t4.issue_const", 64'(issue), 64'h10);
        #2;
        check_now("t4.free");
        advance();

        // Make r3 pending, then same-cycle set/clear on r9 and dual writeback on r3
        dec(1, 3, 0, 0, 3, 3, 1, 1);
        run_cycle("t5.set3");
        dec(1, 5, 0, 0, 9, 0, 1, 0);
        wb(1, 9, 1, 3);
        run_cycle("t5.setclr");
        wb(1, 3, 1, 3);
        dec(1, 6, 3, 0, 0, 0, 0, 0);
        run_cycle("t5.rd3");
        wb(0, 0, 0, 0);
        dec(1, 6, 0, 9, 0, 0, 0, 0);
        run_cycle("t5.rd9a");
        run_cycle("t5.rd9b");
        wb(0, 9, 1, 9);
        run_cycle("t5.wb9");
        wb(0, 0, 0, 0);
        run_cycle("t5.rd9c");

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 2000; c++) begin
            if (!exp_stall_v || !dec_valid) begin
                dec(($urandom_range(0, 9) != 0), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            end
            for (int u = 0; u < 8; u++) begin
                unit_busy[u] = ($urandom_range(0, 7) == 0);
            end
            wb(($urandom_range(0, 2) == 0), $urandom_range(0, 7),
               ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
            run_cycle("rand");
        end

        // Drain, then hold a RAW stall long enough to saturate the narrow counter
        unit_busy = 8'h00;
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 8; r += 2) begin
            wb(1, r, 1, r + 1);
            run_cycle("t6.drain");
        end
        wb(0, 0, 0, 0);
        dec(1, 2, 0, 0, 7, 0, 1, 0);
        run_cycle("t6.set7");
        dec(1, 1, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            run_cycle("t6.hold");
        end
        #1;
        check_val("t6.sat_const", 64'(stall_cycles_s), 64'hF);

        // Asynchronous reset mid-stall
        #1;
        rst_n = 1'b0;
        pend_m  = '0;
        cnt_m   = '0;
        cnt_s_m = '0;
        #1;
        check_val("t6.rst_stall", 64'(stall), 64'd0);
        check_val("t6.rst_cycles", 64'(stall_cycles), 64'd0);
        check_now("t6.rst");
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_now("t6.rst_idle");
        advance();
        rst_n = 1'b1;

        // Late writeback after reset is harmless and r7 reads freely
        wb(1, 7, 0, 0);
        dec(1, 1, 7, 0, 0, 0, 0, 0);
        run_cycle("t6.late_wb");
        wb(0, 0, 0, 0);
        run_cycle("t6.post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
